// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game engine: FSM states, LCD status
// codes and the win/lose effect note tables.
package simon_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_PLAY_TONE,
        S_PLAY_GAP,
        S_WAIT_IN,
        S_HELD,
        S_CHECK,
        S_WIN_FX,
        S_LOSE_FX,
        S_DONE
    } state_e;

    localparam logic [3:0] SC_IDLE = 4'd0;
    localparam logic [3:0] SC_ARM  = 4'd1;
    localparam logic [3:0] SC_PLAY = 4'd2;
    localparam logic [3:0] SC_IN   = 4'd3;
    localparam logic [3:0] SC_WIN  = 4'd4;
    localparam logic [3:0] SC_LOSE = 4'd5;
    localparam logic [3:0] SC_DONE = 4'd6;

    // Effect notes in play order: element [0] sounds first.
    localparam logic [2:0][2:0] FX_WIN  = {3'd6, 3'd5, 3'd4};
    localparam logic [2:0][2:0] FX_LOSE = {3'd1, 3'd2, 3'd3};

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [3:0] state_code_of(state_e s);
        case (s)
            S_IDLE:                     return SC_IDLE;
            S_ARM:                      return SC_ARM;
            S_PLAY_TONE, S_PLAY_GAP:    return SC_PLAY;
            S_WAIT_IN, S_HELD, S_CHECK: return SC_IN;
            S_WIN_FX:                   return SC_WIN;
            S_LOSE_FX:                  return SC_LOSE;
            S_DONE:                     return SC_DONE;
            default:                    return SC_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/simon_core_n_seq_mem.sv
// Sequence RAM: seed write at address 0 or append at address len; the playback
// read port is write-first so a freshly seeded value is visible the same cycle.
module simon_seq_mem
    import simon_pkg::*;
#(
    parameter int BW = 2,
    parameter int LW = 6
) (
    input  logic          clk,
    input  logic          seed_we,
    input  logic          app_we,
    input  logic [LW-1:0] len,
    input  logic [BW-1:0] wdata,
    input  logic [LW-1:0] chk_addr,
    output logic [BW-1:0] chk_data,
    input  logic [LW-1:0] play_addr,
    output logic [BW-1:0] play_data
);
    localparam int DEPTH = 1 << LW;

    logic [BW-1:0] mem [DEPTH];
    logic          wr_en;
    logic [LW-1:0] wr_addr;

    assign wr_en   = seed_we | app_we;
    assign wr_addr = seed_we ? '0 : len;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wdata;
    end

    assign chk_data  = mem[chk_addr];
    assign play_data = (wr_en && wr_addr == play_addr) ? wdata : mem[play_addr];

endmodule

// File: rtl/simon_core_n.sv
// Simon game engine for NUM_BTNS buttons. Define SIMON_TIMEOUT_EN to make an
// idle WAIT_IN lose the game after TIMEOUT_CYC clocks.
module simon_core_n
    import simon_pkg::*;
#(
    parameter int NUM_BTNS       = 4,
    parameter int MAX_LEN        = 32,
    parameter int TONE_CYC       = 37500000,
    parameter int GAP_CYC        = 12500000,
    parameter int FX_CYC         = 25000000,
    parameter int TIMEOUT_CYC    = 250000000,
    parameter int SPEEDUP_ROUNDS = 8,
    localparam int BW            = $clog2(NUM_BTNS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_held,
    input  logic                start,
    input  logic                replay,
    input  logic [7:0]          rand_in,
    output logic                tone_en,
    output logic                tone_fx,
    output logic [BW:0]         tone_idx,
    output logic                led_en,
    output logic [BW-1:0]       led_idx,
    output logic [7:0]          score,
    output logic [3:0]          state_code,
    output logic                game_over
);
    localparam int TW      = BW + 1;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int MAX_CYC = max2(max2(TONE_CYC, GAP_CYC), max2(FX_CYC, TIMEOUT_CYC));
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] TONE_L  = CW'(TONE_CYC);
    localparam logic [CW-1:0] GAP_END = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] FX_END  = CW'(FX_CYC - 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
`ifdef SIMON_TIMEOUT_EN
    localparam logic [CW-1:0] TO_END  = CW'(TIMEOUT_CYC - 1);
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc, tone_len;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d, rd_nxt, len_q, len_d;
    logic [7:0]    score_q, score_d, spd;
    logic [1:0]    fx_ph_q, fx_ph_d, shift, note_sel;
    logic [BW-1:0] lat_q, lat_d, btn_idx, chk_data, play_data;
    logic          seed_we, app_we, btn_one, btn_multi;

    logic          tone_en_q, tone_en_d, tone_fx_q, tone_fx_d;
    logic [TW-1:0] tone_idx_q, tone_idx_d;
    logic          led_en_q, led_en_d, game_over_q, game_over_d;
    logic [BW-1:0] led_idx_q, led_idx_d;
    logic [3:0]    state_code_q, state_code_d;

    simon_seq_mem #(.BW(BW), .LW(LW)) u_mem (
        .clk       (clk),
        .seed_we   (seed_we),
        .app_we    (app_we),
        .len       (len_q),
        .wdata     (BW'(rand_in)),
        .chk_addr  (rd_ptr_q),
        .chk_data  (chk_data),
        .play_addr (rd_ptr_d),
        .play_data (play_data)
    );

    assign cnt_inc   = cnt_q + 1'b1;
    assign rd_nxt    = rd_ptr_q + 1'b1;
    assign btn_one   = (btn_held != '0) && ((btn_held & (btn_held - 1'b1)) == '0);
    assign btn_multi = (btn_held != '0) && !btn_one;
    assign spd       = score_q / 8'(SPEEDUP_ROUNDS);
    assign shift     = (spd >= 8'd2) ? 2'd2 : 2'(spd);
    assign tone_len  = TONE_L >> shift;

    always_comb begin
        btn_idx = '0;
        for (int i = 0; i < NUM_BTNS; i++)
            if (btn_held[i]) btn_idx = BW'(i);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        score_d  = score_q;
        fx_ph_d  = fx_ph_q;
        lat_d    = lat_q;
        seed_we  = 1'b0;
        app_we   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                score_d = '0;
                len_d   = '0;
                state_d = S_ARM;
            end
            // The release instant samples rand_in, so hold time seeds the game.
            S_ARM: if (!start) begin
                seed_we  = 1'b1;
                len_d    = LW'(1);
                rd_ptr_d = '0;
                cnt_d    = '0;
                state_d  = S_PLAY_TONE;
            end
            S_PLAY_TONE: begin
                if (cnt_q == tone_len - 1'b1) begin
                    cnt_d   = '0;
                    state_d = S_PLAY_GAP;
                end else cnt_d = cnt_inc;
            end
            S_PLAY_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d = '0;
                    if (rd_nxt == len_q) begin
                        rd_ptr_d = '0;
                        state_d  = S_WAIT_IN;
                    end else begin
                        rd_ptr_d = rd_nxt;
                        state_d  = S_PLAY_TONE;
                    end
                end else cnt_d = cnt_inc;
            end
            S_WAIT_IN: begin
                cnt_d = '0;
                if (btn_multi) begin
                    fx_ph_d = '0;
                    state_d = S_LOSE_FX;
                end else if (btn_one) begin
                    lat_d   = btn_idx;
                    state_d = S_HELD;
                end else if (replay && rd_ptr_q == '0) begin
                    state_d = S_PLAY_TONE;
`ifdef SIMON_TIMEOUT_EN
                end else if (cnt_q == TO_END) begin
                    fx_ph_d = '0;
                    state_d = S_LOSE_FX;
                end else begin
                    cnt_d = cnt_inc;
`endif
                end
            end
            S_HELD: if (btn_held == '0) state_d = S_CHECK;
            S_CHECK: begin
                if (lat_q != chk_data) begin
                    fx_ph_d = '0;
                    state_d = S_LOSE_FX;
                end else if (rd_nxt < len_q) begin
                    rd_ptr_d = rd_nxt;
                    state_d  = S_WAIT_IN;
                end else state_d = S_WIN_FX;
            end
            S_WIN_FX: begin
                if (cnt_q == FX_END) begin
                    cnt_d   = '0;
                    fx_ph_d = fx_ph_q + 1'b1;
                    if (fx_ph_q == 2'd3) begin
                        score_d  = (score_q == 8'hFF) ? score_q : score_q + 1'b1;
                        rd_ptr_d = '0;
                        if (len_q == LEN_MAX) begin
                            lat_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            app_we  = 1'b1;
                            len_d   = len_q + 1'b1;
                            state_d = S_PLAY_TONE;
                        end
                    end
                end else cnt_d = cnt_inc;
            end
            S_LOSE_FX: begin
                if (cnt_q == FX_END) begin
                    cnt_d   = '0;
                    fx_ph_d = fx_ph_q + 1'b1;
                    if (fx_ph_q == 2'd3) state_d = S_IDLE;
                end else cnt_d = cnt_inc;
            end
            S_DONE: begin
                if (start) begin
                    score_d = '0;
                    len_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ARM;
                end else if (cnt_q == FX_END) begin
                    cnt_d = '0;
                    lat_d = lat_q + 1'b1;
                end else cnt_d = cnt_inc;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode the next state so they line up with state_q after the edge.
    always_comb begin
        tone_en_d    = 1'b0;
        tone_fx_d    = 1'b0;
        tone_idx_d   = '0;
        led_en_d     = 1'b0;
        led_idx_d    = '0;
        game_over_d  = 1'b0;
        state_code_d = state_code_of(state_d);
        note_sel     = fx_ph_d - 2'd1;
        case (state_d)
            S_PLAY_TONE: begin
                tone_en_d  = 1'b1;
                led_en_d   = 1'b1;
                tone_idx_d = TW'(play_data);
                led_idx_d  = play_data;
            end
            S_HELD: begin
                tone_en_d  = 1'b1;
                led_en_d   = 1'b1;
                tone_idx_d = TW'(lat_d);
                led_idx_d  = lat_d;
            end
            S_WIN_FX: if (fx_ph_d != 2'd0) begin
                tone_en_d  = 1'b1;
                tone_fx_d  = 1'b1;
                tone_idx_d = TW'(FX_WIN[note_sel] - 3'd4);
            end
            S_LOSE_FX: begin
                game_over_d = 1'b1;
                if (fx_ph_d != 2'd0) begin
                    tone_en_d  = 1'b1;
                    tone_fx_d  = 1'b1;
                    tone_idx_d = TW'(FX_LOSE[note_sel]);
                end
            end
            S_DONE: begin
                game_over_d = 1'b1;
                led_en_d    = 1'b1;
                led_idx_d   = lat_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            score_q      <= '0;
            fx_ph_q      <= '0;
            lat_q        <= '0;
            tone_en_q    <= 1'b0;
            tone_fx_q    <= 1'b0;
            tone_idx_q   <= '0;
            led_en_q     <= 1'b0;
            led_idx_q    <= '0;
            game_over_q  <= 1'b0;
            state_code_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            score_q      <= score_d;
            fx_ph_q      <= fx_ph_d;
            lat_q        <= lat_d;
            tone_en_q    <= tone_en_d;
            tone_fx_q    <= tone_fx_d;
            tone_idx_q   <= tone_idx_d;
            led_en_q     <= led_en_d;
            led_idx_q    <= led_idx_d;
            game_over_q  <= game_over_d;
            state_code_q <= state_code_d;
        end
    end

    assign tone_en    = tone_en_q;
    assign tone_fx    = tone_fx_q;
    assign tone_idx   = tone_idx_q;
    assign led_en     = led_en_q;
    assign led_idx    = led_idx_q;
    assign score      = score_q;
    assign state_code = state_code_q;
    assign game_over  = game_over_q;

endmodule
